// File: rtl/imem_loader_pkg.sv
// Shared encodings and sizes for the instruction-memory boot loader.
// Included by imem_loader and imem_byte_packer via import imem_loader_pkg::*.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W    = 9;
  localparam int INST_W         = 16;
  localparam int IMEM_MAX_WORDS = 256;

  localparam logic [3:0] IMEM_LD_IDLE    = 4'd0;
  localparam logic [3:0] IMEM_LD_LEN_HI  = 4'd1;
  localparam logic [3:0] IMEM_LD_LEN_LO  = 4'd2;
  localparam logic [3:0] IMEM_LD_DATA_HI = 4'd3;
  localparam logic [3:0] IMEM_LD_DATA_LO = 4'd4;
  localparam logic [3:0] IMEM_LD_WRITE   = 4'd5;
  localparam logic [3:0] IMEM_LD_CHK     = 4'd6;
  localparam logic [3:0] IMEM_LD_DONE    = 4'd7;
  localparam logic [3:0] IMEM_LD_ERR     = 4'd8;

  // States in which the loader consumes a stream byte.
  function automatic logic ld_takes_byte(input logic [3:0] st);
    case (st)
      IMEM_LD_LEN_HI, IMEM_LD_LEN_LO, IMEM_LD_DATA_HI,
      IMEM_LD_DATA_LO, IMEM_LD_CHK: ld_takes_byte = 1'b1;
      default:                      ld_takes_byte = 1'b0;
    endcase
  endfunction

  function automatic logic ld_is_busy(input logic [3:0] st);
    ld_is_busy = ld_takes_byte(st) || (st == IMEM_LD_WRITE);
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Latches hi then lo data byte and presents {hi,lo} with a word_rdy pulse the cycle after lo.
// Keeps the running 8-bit data-byte sum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_hi_we,
  input  logic              i_lo_we,
  input  logic [7:0]        i_byte,
  output logic [INST_W-1:0] o_word,
  output logic              o_word_rdy
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        o_sum8
`endif
);

  logic [7:0] r_hi;
  logic [7:0] r_lo;
  logic       r_word_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi       <= 8'h00;
      r_lo       <= 8'h00;
      r_word_rdy <= 1'b0;
    end else begin
      r_word_rdy <= i_lo_we;
      if (i_hi_we) r_hi <= i_byte;
      if (i_lo_we) r_lo <= i_byte;
    end
  end

  assign o_word     = {r_hi, r_lo};
  assign o_word_rdy = r_word_rdy;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum8 <= 8'h00;
    end else if (i_clr) begin
      r_sum8 <= 8'h00;
    end else if (i_hi_we || i_lo_we) begin
      r_sum8 <= r_sum8 + i_byte;
    end
  end

  assign o_sum8 = r_sum8;
`endif

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> 16-bit imem writes at 0,2,4,..; cpu held while busy.
// >=3 cycles per word, byte_ready low in WRITE/IDLE/DONE/ERR; IMEM_LOADER_CHECKSUM_EN adds a trailing sum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int DATA_W    = INST_W,
  parameter int MAX_WORDS = IMEM_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [3:0] ST_TAIL = IMEM_LD_CHK;
`else
  localparam logic [3:0] ST_TAIL = IMEM_LD_DONE;
`endif

  logic [3:0]        r_state;
  logic [3:0]        w_state_nxt;
  logic [7:0]        r_len_hi;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-2:0] r_idx;

  logic              w_accept;
  logic              w_start;
  logic [15:0]       w_len;
  logic              w_last;
  logic              w_hi_we;
  logic              w_lo_we;
  logic [INST_W-1:0] w_word;
  logic              w_word_rdy;

  assign byte_ready = ld_takes_byte(r_state);
  assign w_accept   = byte_valid && byte_ready;
  assign w_start    = start && !ld_is_busy(r_state);
  assign w_len      = {r_len_hi, byte_in};
  assign w_last     = (ADDR_W'(r_idx) == (r_len - ADDR_W'(1)));
  assign w_hi_we    = w_accept && (r_state == IMEM_LD_DATA_HI);
  assign w_lo_we    = w_accept && (r_state == IMEM_LD_DATA_LO);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] w_sum8;
  logic [7:0] w_chk_total;

  assign w_chk_total = w_sum8 + byte_in;
`endif

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_start),
    .i_hi_we    (w_hi_we),
    .i_lo_we    (w_lo_we),
    .i_byte     (byte_in),
    .o_word     (w_word),
    .o_word_rdy (w_word_rdy)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .o_sum8     (w_sum8)
`endif
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IMEM_LD_IDLE, IMEM_LD_DONE, IMEM_LD_ERR: begin
        if (w_start) w_state_nxt = IMEM_LD_LEN_HI;
      end
      IMEM_LD_LEN_HI: begin
        if (w_accept) w_state_nxt = IMEM_LD_LEN_LO;
      end
      IMEM_LD_LEN_LO: begin
        if (w_accept) begin
          if (w_len == 16'd0)                  w_state_nxt = ST_TAIL;
          else if (w_len > 16'(MAX_WORDS))     w_state_nxt = IMEM_LD_ERR;
          else                                 w_state_nxt = IMEM_LD_DATA_HI;
        end
      end
      IMEM_LD_DATA_HI: begin
        if (w_accept) w_state_nxt = IMEM_LD_DATA_LO;
      end
      IMEM_LD_DATA_LO: begin
        if (w_accept) w_state_nxt = IMEM_LD_WRITE;
      end
      IMEM_LD_WRITE: begin
        w_state_nxt = w_last ? ST_TAIL : IMEM_LD_DATA_HI;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      IMEM_LD_CHK: begin
        if (w_accept) w_state_nxt = (w_chk_total == 8'h00) ? IMEM_LD_DONE : IMEM_LD_ERR;
      end
`endif
      default: w_state_nxt = IMEM_LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IMEM_LD_IDLE;
      r_len_hi <= 8'h00;
      r_len    <= '0;
      r_idx    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_idx <= '0;
      end
      if (w_accept && (r_state == IMEM_LD_LEN_HI)) begin
        r_len_hi <= byte_in;
      end
      if (w_accept && (r_state == IMEM_LD_LEN_LO)) begin
        r_len <= w_len[ADDR_W-1:0];
      end
      // Index stays on the last word so it can never wrap past MAX_WORDS-1.
      if ((r_state == IMEM_LD_WRITE) && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign mem_we    = (r_state == IMEM_LD_WRITE) && w_word_rdy;
  assign mem_addr  = {r_idx, 1'b0};
  assign mem_wdata = w_word;
  assign busy      = ld_is_busy(r_state);
  assign cpu_hold  = busy;
  assign done      = (r_state == IMEM_LD_DONE);
  assign error     = (r_state == IMEM_LD_ERR);

endmodule
